// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared state encoding and default geometry for the data-memory arbiter.
package data_mem_arb_pkg;
   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
   localparam int MEM_DEPTH = 64;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 6;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational grant selection; round-robin when DATA_MEM_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
   parameter int N = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
`ifdef DATA_MEM_ARB_RR_EN
   input  logic [IW-1:0] last_grant_i,
`endif
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);
   always_comb begin
      idx_o = '0;
`ifdef DATA_MEM_ARB_RR_EN
      // walk the ring backwards so the slot right after last_grant is written last and wins
      for (int k = N; k >= 1; k--) begin
         if (req_i[(int'(last_grant_i) + k) % N]) idx_o = IW'((int'(last_grant_i) + k) % N);
      end
`else
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[k]) idx_o = IW'(k);
      end
`endif
      gnt_o = (|req_i) ? N'(1) << idx_o : '0;
   end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares a single-port data memory between NUM_REQ requesters, one access per
// two cycles; DATA_MEM_ARB_RR_EN selects round-robin instead of fixed-priority arbitration.
module data_mem_arbiter import data_mem_arb_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = data_mem_arb_pkg::ADDR_W,
   parameter int DATA_W  = data_mem_arb_pkg::DATA_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic [31:0]                 mem_addr,
   output logic [31:0]                 mem_wr_data,
   output logic                        mem_wmem,
   input  logic [31:0]                 mem_dout,
   output logic                        busy
);
   localparam int IW = $clog2(NUM_REQ);
   state_e              state_q;
   logic [IW-1:0]       g_q, idx;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;
   logic [NUM_REQ-1:0]  gnt, rsp_valid_q;
`ifdef DATA_MEM_ARB_RR_EN
   logic [IW-1:0]       last_q;
   rr_arbiter #(.N(NUM_REQ)) u_arb (.req_i(req_valid), .last_grant_i(last_q), .gnt_o(gnt), .idx_o(idx));
`else
   rr_arbiter #(.N(NUM_REQ)) u_arb (.req_i(req_valid), .gnt_o(gnt), .idx_o(idx));
`endif
   // rst gates ready combinationally so no accept can be signalled while reset is held
   assign req_ready   = (state_q == IDLE && !rst) ? gnt : '0;
   assign busy        = state_q == ACCESS;
   assign mem_wmem    = state_q == ACCESS && we_q;
   assign mem_addr    = 32'(addr_q);
   assign mem_wr_data = 32'(wdata_q);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         g_q         <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= '0;
`ifdef DATA_MEM_ARB_RR_EN
         last_q      <= IW'(NUM_REQ - 1);
`endif
      end else begin
         rsp_valid_q <= '0;
         if (state_q == IDLE) begin
            if (|req_valid) begin
               state_q <= ACCESS;
               g_q     <= idx;
               we_q    <= req_we[idx];
               addr_q  <= req_addr[idx*ADDR_W +: ADDR_W];
               wdata_q <= req_wdata[idx*DATA_W +: DATA_W];
`ifdef DATA_MEM_ARB_RR_EN
               last_q  <= idx;
`endif
            end
         end else begin
            state_q          <= IDLE;
            rsp_valid_q[g_q] <= 1'b1;
            if (!we_q) rdata_q <= mem_dout[DATA_W-1:0];
         end
      end
   end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of the two-requester arbiter against a behavioural 64x32 memory.
module tb_data_mem_arbiter;
   logic        clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
   logic [1:0]  req_valid = '0, req_we = '0, req_ready, rsp_valid;
   logic [11:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [31:0] rsp_rdata, mem_addr, mem_wr_data, mem_dout;
   logic        mem_wmem, busy;
   logic [31:0] mem [64];
   int          n_cmp = 0, n_err = 0;
   logic [1:0]  g_exp [4];
   logic [31:0] d_exp [4];

   data_mem_arbiter #(.NUM_REQ(2), .ADDR_W(6), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wmem(mem_wmem), .mem_dout(mem_dout),
      .busy(busy));

   always #5 clk = ~clk;
   assign mem_dout = mem[mem_addr[5:0]];
   always @(posedge clk) begin
      if (mem_init) for (int i = 0; i < 64; i++) mem[i] <= 32'h800000FF;
      else if (mem_wmem) mem[mem_addr[5:0]] <= mem_wr_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      step();
      step();
      mem_init = 1'b0;
      check("rst_busy", 32'(busy), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_wmem", 32'(mem_wmem), 0);
      check("rst_ready", 32'(req_ready), 0);
      rst = 1'b0;
      step();
      // requester 0 reads address 5
      req_valid = 2'b01; req_we = 2'b00; req_addr[5:0] = 6'd5;
      #1 check("rd_ready_T", 32'(req_ready), 32'b01);
      step();
      req_valid = 2'b00;
      check("rd_busy_T1", 32'(busy), 1);
      check("rd_wmem_T1", 32'(mem_wmem), 0);
      check("rd_addr_T1", mem_addr, 5);
      step();
      check("rd_rsp_valid_T2", 32'(rsp_valid), 32'b01);
      check("rd_rdata_T2", rsp_rdata, 32'h800000FF);
      check("rd_busy_T2", 32'(busy), 0);
      // requester 1 writes DEADBEEF to address 10
      req_valid = 2'b10; req_we = 2'b10; req_addr[11:6] = 6'd10; req_wdata[63:32] = 32'hDEADBEEF;
      #1 check("wr_ready_T", 32'(req_ready), 32'b10);
      step();
      req_valid = 2'b00;
      check("wr_wmem_T1", 32'(mem_wmem), 1);
      check("wr_addr_T1", mem_addr, 10);
      check("wr_data_T1", mem_wr_data, 32'hDEADBEEF);
      step();
      check("wr_wmem_T2", 32'(mem_wmem), 0);
      check("wr_rsp_valid_T2", 32'(rsp_valid), 32'b10);
      check("wr_rdata_held", rsp_rdata, 32'h800000FF);
      // both hold valid; requester 0 re-reads address 10, requester 1 reads address 21
      req_we = 2'b00; req_addr = {6'd21, 6'd10};
`ifdef DATA_MEM_ARB_RR_EN
      g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
      d_exp = '{32'hDEADBEEF, 32'h800000FF, 32'hDEADBEEF, 32'h800000FF};
`else
      g_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
      d_exp = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
`endif
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1 check($sformatf("hold_ready_%0d", k), 32'(req_ready), 32'(g_exp[k]));
         if (k > 0) begin
            check($sformatf("hold_rsp_%0d", k - 1), 32'(rsp_valid), 32'(g_exp[k-1]));
            check($sformatf("hold_rdata_%0d", k - 1), rsp_rdata, d_exp[k-1]);
         end
         step();
         if (k == 3) req_valid = 2'b00;
         check($sformatf("hold_busy_%0d", k), 32'(busy), 1);
         step();
      end
      check("hold_rsp_3", 32'(rsp_valid), 32'(g_exp[3]));
      check("hold_rdata_3", rsp_rdata, d_exp[3]);
      // requester 1 raises valid during requester 0's access, then withdraws before any grant
      req_valid = 2'b01; req_addr[5:0] = 6'd5;
      #1 check("wd_ready0", 32'(req_ready), 32'b01);
      step();
      req_valid = 2'b10;
      #1 check("wd_ready_busy", 32'(req_ready), 0);
      req_valid = 2'b00;
      step();
      check("wd_rsp0", 32'(rsp_valid), 32'b01);
      check("wd_busy", 32'(busy), 0);
      step();
      check("wd_no_rsp1", 32'(rsp_valid), 0);
      check("wd_no_access", 32'(busy), 0);
      req_valid = 2'b11;
`ifdef DATA_MEM_ARB_RR_EN
      #1 check("wd_last_kept", 32'(req_ready), 32'b10);
`else
      #1 check("wd_last_kept", 32'(req_ready), 32'b01);
`endif
      req_valid = 2'b00;
      step();
      // reset during a write to address 3
      req_valid = 2'b01; req_we = 2'b01; req_addr[5:0] = 6'd3; req_wdata[31:0] = 32'h12345678;
      step();
      check("rst_mid_wmem_before", 32'(mem_wmem), 1);
      rst = 1'b1;
      #1 check("rst_mid_wmem_async", 32'(mem_wmem), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_ready", 32'(req_ready), 0);
      step();
      check("rst_mid_no_rsp", 32'(rsp_valid), 0);
      check("rst_mid_ready2", 32'(req_ready), 0);
      check("rst_mid_mem3", mem[3], 32'h800000FF);
      req_valid = 2'b00; req_we = 2'b00;
      rst = 1'b0;
      step();
      check("rst_mid_rsp_after", 32'(rsp_valid), 0);
      // back-to-back writes from requester 0 to addresses 40..42
      req_valid = 2'b01; req_we = 2'b01;
      for (int k = 0; k < 3; k++) begin
         req_addr[5:0] = 6'(40 + k); req_wdata[31:0] = 32'(k + 1);
         #1 check($sformatf("b2b_ready_%0d", k), 32'(req_ready), 32'b01);
         if (k > 0) check($sformatf("b2b_rsp_%0d", k - 1), 32'(rsp_valid), 32'b01);
         step();
         if (k == 2) req_valid = 2'b00;
         check($sformatf("b2b_gap_ready_%0d", k), 32'(req_ready), 0);
         check($sformatf("b2b_gap_rsp_%0d", k), 32'(rsp_valid), 0);
         step();
      end
      check("b2b_rsp_2", 32'(rsp_valid), 32'b01);
      check("b2b_mem41", mem[41], 32'd2);
      check("b2b_mem42", mem[42], 32'd3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port 64x32 data memory of the monocycle CPU between `NUM_REQ` requesters (CPU load/store unit, debug/DMA port, ...). Each requester issues read or write requests over a valid/ready handshake. A round-robin arbiter picks one request at a time, drives the memory's address/write-data/write-enable pins, and returns a registered response (read data or write acknowledge) to the winner. The memory itself is external to this block; its read path is combinational and its write occurs at posedge `clk` when `wmem` is high.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `ADDR_W`, 6: word-address width; the memory depth is 2^ADDR_W = 64.
- `DATA_W`, 32: data width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  word address, packed; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  write data, packed the same way.
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle response strobe.
- `rsp_rdata`  out  DATA_W  read data, shared by all requesters; qualified by `rsp_valid`.
- `mem_addr`  out  32  memory address = zero-extended latched address.
- `mem_wr_data`  out  32  memory write data.
- `mem_wmem`  out  1  memory write enable.
- `mem_dout`  in  32  memory combinational read data.
- `busy`  out  1  high while in state ACCESS.

## Operation
- FSM with two states, IDLE and ACCESS. Reset state is IDLE.
- **IDLE, any `req_valid` set:**
  - The arbiter selects winner g.
  - `req_ready[g]` = 1 combinationally in that same cycle.
  - At the clock edge, latch g, `req_we[g]`, `req_addr[g]` and `req_wdata[g]`, then go to ACCESS.
- **IDLE, no valid:** stay in IDLE; all `req_ready` = 0.
- **ACCESS:**
  - `mem_addr`, `mem_wr_data` and `mem_wmem` (= latched we) are driven from the latched registers.
  - For a read, `mem_dout` is captured into the `rsp_rdata` register. For a write, `rsp_rdata` holds its previous value.
  - `rsp_valid[g]` is registered to 1 for the next cycle.
  - The FSM always returns to IDLE.
- **Requester obligation:** hold valid, we, addr and wdata stable until `req_ready` is seen. Withdrawing a request before it is accepted is allowed and has no effect.
- **Arbitration:**
  - Round-robin; the search starts at index (last_grant+1) mod NUM_REQ.
  - `last_grant` updates only on an accept.
  - `last_grant` resets to NUM_REQ-1, so requester 0 wins first after reset.
- **Outside ACCESS:** `mem_wmem` = 0. `mem_addr` and `mem_wr_data` keep their latched values.
- **Reset values:** state = IDLE, `req_ready` = 0 (forced low while `rst` is high), `rsp_valid` = 0, `rsp_rdata` = 0, `mem_addr` = 0, `mem_wr_data` = 0, `mem_wmem` = 0, `busy` = 0.
- **Reset mid-ACCESS:** the state drops to IDLE asynchronously, so `mem_wmem` falls immediately. No response is generated; the requester must reissue.
- **Simultaneous events:** a `rsp_valid` pulse and a new accept may occur in the same IDLE cycle.

## Timing
- Accept at cycle T (`req_valid[g]` & `req_ready[g]`).
- Memory access in cycle T+1; a write commits at the edge closing T+1.
- `rsp_valid[g]` and `rsp_rdata` appear in cycle T+2, one cycle wide.
- Peak throughput is one request every 2 cycles.
- Read-after-write to the same address from any requester returns the new data, because accesses are strictly serialized.

## Configuration
- `DATA_MEM_ARB_RR_EN` defined: round-robin arbitration as described above.
- `DATA_MEM_ARB_RR_EN` undefined: fixed priority, lowest index wins. `last_grant` is not implemented.

## Structure
- **Package `data_mem_arb_pkg`:**
  - State enum (IDLE = 1'b0, ACCESS = 1'b1).
  - Default constants MEM_DEPTH = 64, DATA_W = 32, ADDR_W = 6.
- **Sub-module `rr_arbiter`:**
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the `last_grant` register lives in the parent.
  - Contains the `DATA_MEM_ARB_RR_EN` switch.

## Test plan
- After reset, all memory words are 0x800000FF. Requester 0 reads addr 5: `req_ready[0]` at T, `mem_wmem` = 0 at T+1, `rsp_valid[0]` = 1 with `rsp_rdata` = 0x800000FF at T+2.
- Requester 1 writes 0xDEADBEEF to addr 10, then requester 0 reads addr 10: `mem_wmem` is high for exactly 1 cycle, and the read returns 0xDEADBEEF.
- Both requesters hold valid continuously with distinct addresses. Grants alternate 0,1,0,1 with RR enabled, and stay on 0 only when the macro is undefined.
- Assert `rst` during ACCESS of a write to addr 3: `mem_wmem` falls without waiting for a clock, no `rsp_valid` pulse occurs, and `req_ready` stays 0 while `rst` is high.
- Back-to-back requests from requester 0: `rsp_valid` of request k and `req_ready` of request k+1 occur in the same cycle, at a spacing of 2 cycles.
- Requester 1 drops `req_valid` before being granted: no access and no response for requester 1, and `last_grant` is unchanged.
